// File: rtl/divider8_pkg.sv
// divider8_pkg: shared types and constants for the sequential restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    localparam int DIV_WIDTH = 8;
    localparam int DIV_ITER_LAST = 7;
endpackage

// File: rtl/divider8_if.sv
// divider8_if: start/done handshake, operands and results of the divider.
interface divider8_if;
    import div_pkg::*;
    logic start;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic busy;
    logic done;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider8_adder8.sv
// adder8: 8-bit combinational adder with carry in and carry out.
module adder8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       carry_i,
    output logic [7:0] sum_o,
    output logic       carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'b0, carry_i};
endmodule

// File: rtl/divider8.sv
// divider8: unsigned restoring divider, one quotient bit per clock via adder8 subtraction.
module divider8
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    divider8_if.slave  bus
);
    div_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic dbz_q, dbz_d;
    logic msb, carry, take;
    logic [DIV_WIDTH-1:0] r_sh, diff, r_nx, q_nx;
    assign {msb, r_sh} = {r_q, q_q[DIV_WIDTH-1]};
    // ~d with carry-in 1 turns the adder into r_sh - d; carry out means no borrow
    adder8 u_sub (
        .a_i     (r_sh),
        .b_i     (~d_q),
        .carry_i (1'b1),
        .sum_o   (diff),
        .carry_o (carry)
    );
    assign take = msb | carry;
    assign r_nx = take ? diff : r_sh;
    assign q_nx = {q_q[DIV_WIDTH-2:0], take};
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        r_d = r_q;
        q_d = q_q;
        d_d = d_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                cnt_d = '0;
                r_d = '0;
                q_d = bus.dividend;
                d_d = bus.divisor;
            end
            RUN: if (d_q == '0) begin
                state_d = DONE;
                quo_d = '1;
                rem_d = q_q;
                dbz_d = 1'b1;
            end else begin
                r_d = r_nx;
                q_d = q_nx;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(DIV_ITER_LAST)) begin
                    state_d = DONE;
                    quo_d = q_nx;
                    rem_d = r_nx;
                    dbz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == DONE;
    assign bus.quotient = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider8.sv
// tb_divider8: directed and random divisions checked against plain / and % arithmetic.
module tb_divider8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    divider8_if bus();
    divider8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic run_div(input logic [7:0] a, input logic [7:0] b);
        int n;
        logic [7:0] eq, er;
        eq = (b == 0) ? 8'hFF : 8'(a / b);
        er = (b == 0) ? a : 8'(a % b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = ~a;
        bus.divisor = ~b;
        chk($sformatf("busy_after_accept %0d/%0d", a, b), bus.busy, 1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("latency %0d/%0d", a, b), n, (b == 0) ? 1 : 8);
        chk($sformatf("quotient %0d/%0d", a, b), bus.quotient, eq);
        chk($sformatf("remainder %0d/%0d", a, b), bus.remainder, er);
        chk($sformatf("dbz %0d/%0d", a, b), bus.div_by_zero, b == 0);
        @(posedge clk);
        #1;
        chk($sformatf("idle_busy %0d/%0d", a, b), bus.busy, 0);
        chk($sformatf("idle_done %0d/%0d", a, b), bus.done, 0);
        chk($sformatf("hold_quotient %0d/%0d", a, b), bus.quotient, eq);
    endtask
    initial begin
        int n_done;
        logic [7:0] cq, cr;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_quotient", bus.quotient, 0);
        chk("reset_remainder", bus.remainder, 0);
        chk("reset_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        run_div(100, 7);
        run_div(255, 128);
        run_div(200, 250);
        run_div(255, 1);
        run_div(0, 9);
        run_div(37, 0);
        run_div(128, 255);
        for (int i = 0; i < 25; i++)
            run_div(8'($urandom), ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 100;
        bus.divisor = 7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_done = 0;
        cq = '0;
        cr = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 50;
        bus.divisor = 5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                n_done++;
                cq = bus.quotient;
                cr = bus.remainder;
            end
        end
        chk("ignored_start_done_count", n_done, 1);
        chk("ignored_start_quotient", cq, 14);
        chk("ignored_start_remainder", cr, 2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 200;
        bus.divisor = 3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrun_reset_busy", bus.busy, 0);
        chk("midrun_reset_done", bus.done, 0);
        chk("midrun_reset_quotient", bus.quotient, 0);
        chk("midrun_reset_remainder", bus.remainder, 0);
        chk("midrun_reset_dbz", bus.div_by_zero, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) n_done++;
        end
        chk("midrun_reset_no_activity", n_done, 0);
        run_div(200, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
